// File: rtl/float_add_pipe_if.sv
// Operand/result handshake bundle for float_add_pipe.
// The master drives operands and out_ready; the slave (the adder) returns in_ready and the result.
interface float_add_pipe_if #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/float_add_pipe.sv
// Three-stage pipelined signed float adder/subtractor: align, add, normalise/round/pack.
// Define FLOAT_ADD_PIPE_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module float_add_pipe #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    float_add_pipe_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;      // significand with hidden bit
    localparam int AW = MAN_W + 4;      // significand + guard, round, sticky
    localparam int MW = MAN_W + 5;      // adder width incl. carry-out
    localparam int XW = 2 * MAN_W + 4;  // alignment shifter width
    localparam int EW = EXP_W + 1;      // exponent with overflow headroom
    localparam int unsigned SH_MAX = MAN_W + 3;

    logic adv;

    logic              s1_valid_q, s1_sign_q, s1_sub_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [SW-1:0]     s1_sigx_q;
    logic [AW-1:0]     s1_yal_q;
    logic              s1_sign_d, s1_sub_d;
    logic [EXP_W-1:0]  s1_exp_d;
    logic [SW-1:0]     s1_sigx_d;
    logic [AW-1:0]     s1_yal_d;

    logic              s2_valid_q, s2_sign_q;
    logic [EXP_W-1:0]  s2_exp_q;
    logic [MW-1:0]     s2_mag_q;
    logic [MW-1:0]     s2_mag_d;

    logic              out_valid_q, ovf_q, ovf_d;
    logic [W-1:0]      sum_q, sum_d;

    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.ovf       = ovf_q;

    // Stage 1: order operands by magnitude so X >= Y, then align Y to X.
    logic [W-2:0]      x_mag, y_mag;
    logic              b_sign;
    logic [EXP_W-1:0]  ey, dexp;
    logic [SW-1:0]     sig_y;
    int unsigned       shamt;
    logic [XW-1:0]     wide;

    always_comb begin
        // NOTE: every variable gets a value on every path, so no latch can be inferred.
        b_sign   = bus.b[W-1] ^ bus.op;
        s1_sub_d = bus.a[W-1] ^ b_sign;
        if (bus.a[W-2:0] >= bus.b[W-2:0]) begin
            x_mag     = bus.a[W-2:0];
            y_mag     = bus.b[W-2:0];
            s1_sign_d = bus.a[W-1];
        end else begin
            x_mag     = bus.b[W-2:0];
            y_mag     = bus.a[W-2:0];
            s1_sign_d = b_sign;
        end
        s1_exp_d  = (x_mag[W-2:MAN_W] == '0) ? EXP_W'(1) : x_mag[W-2:MAN_W];
        ey        = (y_mag[W-2:MAN_W] == '0) ? EXP_W'(1) : y_mag[W-2:MAN_W];
        s1_sigx_d = {x_mag[W-2:MAN_W] != '0, x_mag[MAN_W-1:0]};
        sig_y     = {y_mag[W-2:MAN_W] != '0, y_mag[MAN_W-1:0]};
        dexp      = s1_exp_d - ey;
        shamt     = (32'(dexp) > SH_MAX) ? SH_MAX : 32'(dexp);
        wide      = {sig_y, {(MAN_W + 3){1'b0}}} >> shamt;
        s1_yal_d  = {wide[XW-1 -: MAN_W + 3], |wide[MAN_W:0]};
    end

    // Stage 2: magnitude add/subtract; X >= Y keeps the result non-negative.
    always_comb begin
        s2_mag_d = s1_sub_q ? ({1'b0, s1_sigx_q, 3'b000} - {1'b0, s1_yal_q})
                            : ({1'b0, s1_sigx_q, 3'b000} + {1'b0, s1_yal_q});
    end

    // Stage 3: normalise, round, detect overflow and pack.
    int              lzc, sh;
    logic [AW-1:0]   nm;
    logic [SW:0]     rsig;
    logic [EW-1:0]   e;

    always_comb begin
        lzc = AW;
        for (int i = 0; i < AW; i++) begin
            if (s2_mag_q[i]) lzc = AW - 1 - i;
        end
        e  = EW'(s2_exp_q);
        sh = 0;
        if (s2_mag_q[MW-1]) begin
            nm = {s2_mag_q[MW-1:2], s2_mag_q[1] | s2_mag_q[0]};
            e  = e + EW'(1);
        end else begin
            sh = (lzc < int'(s2_exp_q) - 1) ? lzc : int'(s2_exp_q) - 1;
            nm = s2_mag_q[AW-1:0] << sh;
            e  = (sh == lzc) ? e - EW'(sh) : '0;
        end
        rsig = {1'b0, nm[AW-1:3]};
`ifdef FLOAT_ADD_PIPE_RNE_EN
        if (nm[2] && (nm[3] || nm[1] || nm[0])) rsig = rsig + (SW + 1)'(1);
`endif
        if (rsig[SW]) begin
            rsig = rsig >> 1;
            e    = e + EW'(1);
        end
        // A denormal that rounds up into the hidden bit becomes the smallest normal.
        if (e == '0 && rsig[SW-1]) e = EW'(1);

        ovf_d = 1'b0;
        if (nm == '0) begin
            sum_d = '0;
        end else if (e[EXP_W]) begin
            sum_d = {s2_sign_q, {(W - 1){1'b1}}};
            ovf_d = 1'b1;
        end else begin
            sum_d = {s2_sign_q, e[EXP_W-1:0], rsig[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= bus.in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: datapath stage registers are not reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign_q <= s1_sign_d;
            s1_sub_q  <= s1_sub_d;
            s1_exp_q  <= s1_exp_d;
            s1_sigx_q <= s1_sigx_d;
            s1_yal_q  <= s1_yal_d;
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s1_exp_q;
            s2_mag_q  <= s2_mag_d;
        end
    end
endmodule

// File: tb/tb_float_add_pipe.sv
// Self-checking bench for float_add_pipe: directed cases, stall/reset scenarios and random traffic
// scored against an exact integer model of the number format.
module tb_float_add_pipe;
    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int W     = 1 + EXP_W + MAN_W;

`ifdef FLOAT_ADD_PIPE_RNE_EN
    localparam logic [W-1:0] T3_SUM = 8'h3A;
`else
    localparam logic [W-1:0] T3_SUM = 8'h39;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float_add_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    float_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] sum;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           last_lat = -1;
    logic         acc = 1'b0;
    logic         dir_en = 1'b0;
    logic [W-1:0] dir_sum = '0;
    logic         dir_ovf = 1'b0;
    int           ready_mode = 0;
    int           win_lo = 0;
    int           win_hi = -1;
    logic         stalled = 1'b0;
    logic [W-1:0] stall_sum = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    // Exact value of an encoding, in units of the smallest denormal step.
    function automatic int fval(input logic [W-1:0] f);
        int ef, sig, v;
        ef  = int'(f[W-2:MAN_W]);
        sig = int'(f[MAN_W-1:0]) + ((ef != 0) ? (1 << MAN_W) : 0);
        v   = sig << ((ef == 0) ? 0 : ef - 1);
        return f[W-1] ? -v : v;
    endfunction

    // Returns {ovf, sum}: exact sum, then re-encoded with the configured rounding.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int   s, m, sh, q;
        logic sg;
        s = fval(a) + (op ? -fval(b) : fval(b));
        if (s == 0) return '0;
        sg = (s < 0);
        m  = sg ? -s : s;
        if (m < (1 << MAN_W)) return {1'b0, sg, EXP_W'(0), MAN_W'(m)};
        sh = 0;
        while ((m >> sh) >= (1 << (MAN_W + 1))) sh++;
        q = m >> sh;
`ifdef FLOAT_ADD_PIPE_RNE_EN
        if (sh > 0) begin
            int rem, half;
            rem  = m - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
        end
`endif
        if (q == (1 << (MAN_W + 1))) begin
            q  = q >> 1;
            sh = sh + 1;
        end
        if (sh + 1 > (1 << EXP_W) - 1) return {1'b1, sg, {(W - 1){1'b1}}};
        return {1'b0, sg, EXP_W'(sh + 1), MAN_W'(q)};
    endfunction

    // One clock: score handshakes at the falling edge, then advance past the rising edge.
    task automatic cycle();
        exp_t ex;
        logic [W:0] m;
        @(negedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            sb_q.delete();
            stalled = 1'b0;
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                check("in_ready_stall", 32'(bus.in_ready), 32'd0);
                if (stalled) check("hold_sum", 32'(bus.sum), 32'(stall_sum));
                stalled   = 1'b1;
                stall_sum = bus.sum;
            end else begin
                stalled = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    ex = sb_q.pop_front();
                    check($sformatf("sum a=%h b=%h op=%0d", ex.a, ex.b, ex.op), 32'(bus.sum), 32'(ex.sum));
                    check($sformatf("ovf a=%h b=%h op=%0d", ex.a, ex.b, ex.op), 32'(bus.ovf), 32'(ex.ovf));
                    last_lat = cyc - ex.cyc;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                acc    = 1'b1;
                ex.a   = bus.a;
                ex.b   = bus.b;
                ex.op  = bus.op;
                ex.cyc = cyc;
                if (dir_en) begin
                    ex.sum = dir_sum;
                    ex.ovf = dir_ovf;
                end else begin
                    m      = model(bus.a, bus.b, bus.op);
                    ex.sum = m[W-1:0];
                    ex.ovf = m[W];
                end
                sb_q.push_back(ex);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = !(cyc >= win_lo && cyc <= win_hi);
            default: bus.out_ready = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input logic dir, input logic [W-1:0] ds, input logic dov);
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        bus.in_valid = 1'b1;
        dir_en       = dir;
        dir_sum      = ds;
        dir_ovf      = dov;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb_q.size() > 0; k++) cycle();
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        for (int k = 0; k < 4; k++) cycle();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        rst_n = 1'b0;
        cycle();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Latency of a lone operation.
        send(8'h30, 8'h30, 1'b0, 1'b1, 8'h40, 1'b0);
        drain();
        check("latency", 32'(last_lat), 32'd3);

        // Directed cases, back to back.
        send(8'h38, 8'h30, 1'b1, 1'b1, 8'h20, 1'b0);
        send(8'h30, 8'hB0, 1'b0, 1'b1, 8'h00, 1'b0);
        send(8'h30, 8'h23, 1'b0, 1'b1, T3_SUM, 1'b0);
        send(8'h30, 8'h21, 1'b0, 1'b1, 8'h38, 1'b0);
        send(8'h7F, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1);
        send(8'hFF, 8'h7F, 1'b1, 1'b1, 8'hFF, 1'b1);
        send(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0);
        send(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0);
        send(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b0);
        send(8'h00, 8'h80, 1'b0, 1'b1, 8'h00, 1'b0);
        send(8'h85, 8'h03, 1'b0, 1'b1, 8'h82, 1'b0);
        drain();

        // Six-op stream with out_ready low for stream cycles 4..8.
        ready_mode = 1;
        win_lo     = cyc + 4;
        win_hi     = cyc + 8;
        for (int i = 0; i < 6; i++) send(8'(8'h28 + i), 8'(8'h19 + 3 * i), 1'(i % 2), 1'b0, '0, 1'b0);
        drain();
        ready_mode = 0;

        // Reset with three operations in flight.
        send(8'h30, 8'h30, 1'b0, 1'b0, '0, 1'b0);
        send(8'h41, 8'h12, 1'b1, 1'b0, '0, 1'b0);
        send(8'h55, 8'hC3, 1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 6; k++) cycle();
        send(8'h30, 8'h30, 1'b0, 1'b1, 8'h40, 1'b0);
        drain();

        // Random traffic with random gaps and back-pressure.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(2) == 0) cycle();
            send(8'($urandom), 8'($urandom), 1'($urandom_range(1)), 1'b0, '0, 1'b0);
        end
        ready_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
